// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared opcodes, access sizes and op-class helpers for the MEM stage
package mem_access_pkg;

   localparam int ALUOP_W = 8;
   typedef logic [ALUOP_W-1:0] alu_op_t;

   localparam alu_op_t EXE_OP_NOP = 8'h00;
   localparam alu_op_t EXE_OP_ADD = 8'h01;
   localparam alu_op_t EXE_OP_LB  = 8'h20;
   localparam alu_op_t EXE_OP_LBU = 8'h21;
   localparam alu_op_t EXE_OP_LH  = 8'h22;
   localparam alu_op_t EXE_OP_LHU = 8'h23;
   localparam alu_op_t EXE_OP_LW  = 8'h24;
   localparam alu_op_t EXE_OP_SB  = 8'h28;
   localparam alu_op_t EXE_OP_SH  = 8'h29;
   localparam alu_op_t EXE_OP_SW  = 8'h2B;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   function automatic logic op_is_load(input alu_op_t op);
      return op inside {EXE_OP_LB, EXE_OP_LBU, EXE_OP_LH, EXE_OP_LHU, EXE_OP_LW};
   endfunction

   function automatic logic op_is_store(input alu_op_t op);
      return op inside {EXE_OP_SB, EXE_OP_SH, EXE_OP_SW};
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-SRAM req/addr_ok/data_ok bus between the MEM stage and memory
interface mem_access_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              dreq;
   logic              dwr;
   logic [1:0]        dsize;
   logic [ADDR_W-1:0] daddr;
   logic [3:0]        dwstrb;
   logic [DATA_W-1:0] dwdata;
   logic              daddr_ok;
   logic              ddata_ok;
   logic [DATA_W-1:0] drdata;

   modport master (
      output dreq, dwr, dsize, daddr, dwstrb, dwdata,
      input  daddr_ok, ddata_ok, drdata
   );

   modport slave (
      input  dreq, dwr, dsize, daddr, dwstrb, dwdata,
      output daddr_ok, ddata_ok, drdata
   );
endinterface

// File: rtl/mem_lane.sv
// rtl/mem_lane.sv - byte-lane steering for stores, alignment checks and load extension
module mem_lane
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  alu_op_t           op_i,
   input  logic [1:0]        addr_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] rdata_i,
   output logic [1:0]        dsize_o,
   output logic [3:0]        dwstrb_o,
   output logic [DATA_W-1:0] dwdata_o,
   output logic [1:0]        misalign_o,
   output logic [DATA_W-1:0] ldata_o
);
   logic [DATA_W-1:0] shifted;
   logic [7:0]        rbyte;
   logic [15:0]       rhalf;

   assign shifted = rdata_i >> {addr_i, 3'b000};
   assign rbyte   = shifted[7:0];
   assign rhalf   = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   always_comb begin
      dsize_o    = SIZE_WORD;
      dwstrb_o   = 4'b0000;
      dwdata_o   = reg1_i;
      misalign_o = 2'b00;
      ldata_o    = rdata_i;
      case (op_i)
         EXE_OP_LB:  begin dsize_o = SIZE_BYTE; ldata_o = {{24{rbyte[7]}}, rbyte}; end
         EXE_OP_LBU: begin dsize_o = SIZE_BYTE; ldata_o = {24'd0, rbyte}; end
         EXE_OP_LH:  begin
            dsize_o = SIZE_HALF; misalign_o[0] = addr_i[0]; ldata_o = {{16{rhalf[15]}}, rhalf};
         end
         EXE_OP_LHU: begin
            dsize_o = SIZE_HALF; misalign_o[0] = addr_i[0]; ldata_o = {16'd0, rhalf};
         end
         EXE_OP_LW:  misalign_o[0] = |addr_i;
         EXE_OP_SB:  begin
            dsize_o = SIZE_BYTE; dwstrb_o = 4'b0001 << addr_i; dwdata_o = {4{reg1_i[7:0]}};
         end
         EXE_OP_SH:  begin
            dsize_o = SIZE_HALF; misalign_o[1] = addr_i[0];
            dwstrb_o = addr_i[1] ? 4'b1100 : 4'b0011; dwdata_o = {2{reg1_i[15:0]}};
         end
         EXE_OP_SW:  begin misalign_o[1] = |addr_i; dwstrb_o = 4'b1111; end
         default: ;
      endcase
   end
endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM stage: drives data-SRAM loads/stores, stalls upstream, feeds MEM/WB
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  alu_op_t           aluop_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] reg1_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [4:0]        waddr_i,
   input  logic              we_i,
   input  logic              wb_stall_i,
   mem_access_if.master      dbus,
   output logic [DATA_W-1:0] wdata_o,
   output logic [4:0]        waddr_o,
   output logic              we_o,
   output logic [1:0]        misalign_o,
   output logic [ADDR_W-1:0] badvaddr_o,
   output logic              stallreq_o
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [1:0]        lane_size, lane_mis;
   logic [3:0]        lane_strb;
   logic [DATA_W-1:0] lane_wdata, lane_ldata;
   logic              is_load, is_mem, go;
   logic              dreq;

   mem_lane #(.DATA_W(DATA_W)) u_lane (
      .op_i       (aluop_i),
      .addr_i     (mem_addr_i[1:0]),
      .reg1_i     (reg1_i),
      .rdata_i    (dbus.drdata),
      .dsize_o    (lane_size),
      .dwstrb_o   (lane_strb),
      .dwdata_o   (lane_wdata),
      .misalign_o (lane_mis),
      .ldata_o    (lane_ldata)
   );

   assign is_load = op_is_load(aluop_i);
   assign is_mem  = is_load | op_is_store(aluop_i);
   assign go      = is_mem && (lane_mis == 2'b00);

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      case (state_q)
         S_IDLE: if (go) state_d = dbus.daddr_ok ? S_WAIT : S_REQ;
         S_REQ:  if (dbus.daddr_ok) state_d = S_WAIT;
         S_WAIT: if (dbus.ddata_ok) begin
            if (is_load) buf_d = lane_ldata;
            state_d = S_DONE;
         end
         default: if (!wb_stall_i) state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
      end
   end

   // Everything is forced low while reset is asserted, independent of the inputs.
   always_comb begin
      dreq       = 1'b0;
      stallreq_o = 1'b0;
      wdata_o    = '0;
      waddr_o    = '0;
      we_o       = 1'b0;
      misalign_o = 2'b00;
      badvaddr_o = '0;
      if (rst) begin
         case (state_q)
            S_IDLE: begin
               if (!is_mem) begin
                  wdata_o = wdata_i;
                  waddr_o = waddr_i;
                  we_o    = we_i;
               end else if (lane_mis != 2'b00) begin
                  misalign_o = lane_mis;
                  badvaddr_o = mem_addr_i;
               end else begin
                  dreq       = 1'b1;
                  stallreq_o = 1'b1;
               end
            end
            S_REQ:  begin dreq = 1'b1; stallreq_o = 1'b1; end
            S_WAIT: stallreq_o = 1'b1;
            default: begin
               wdata_o = buf_q;
               waddr_o = waddr_i;
               we_o    = we_i & is_load;
            end
         endcase
      end
   end

   assign dbus.dreq   = dreq;
   assign dbus.dwr    = dreq & ~is_load;
   assign dbus.dsize  = dreq ? lane_size : 2'b00;
   assign dbus.daddr  = dreq ? mem_addr_i : '0;
   assign dbus.dwstrb = (dreq && !is_load) ? lane_strb : 4'b0000;
   assign dbus.dwdata = dreq ? lane_wdata : '0;
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench with a writeback scoreboard for mem_access
module tb_mem_access;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   alu_op_t     aluop;
   logic [31:0] mem_addr, reg1, wdata_in;
   logic [4:0]  waddr_in;
   logic        we_in, wb_stall;
   logic [31:0] wdata_out, badvaddr;
   logic [4:0]  waddr_out;
   logic        we_out, stallreq;
   logic [1:0]  misalign;

   mem_access_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

   mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .aluop_i    (aluop),
      .mem_addr_i (mem_addr),
      .reg1_i     (reg1),
      .wdata_i    (wdata_in),
      .waddr_i    (waddr_in),
      .we_i       (we_in),
      .wb_stall_i (wb_stall),
      .dbus       (dbus),
      .wdata_o    (wdata_out),
      .waddr_o    (waddr_out),
      .we_o       (we_out),
      .misalign_o (misalign),
      .badvaddr_o (badvaddr),
      .stallreq_o (stallreq)
   );

   int checks = 0;
   int errors = 0;
   // {check_wdata, we, waddr, wdata}
   logic [38:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input string name, input alu_op_t op, input logic [31:0] addr,
                         input logic [31:0] r1, input logic [4:0] wa, input logic wen,
                         input int aok_at, input int dok_after, input logic [31:0] rdata,
                         input logic [31:0] exp_wdata, input int wbs,
                         output logic [3:0] strb, output logic [31:0] dwd,
                         output logic [1:0] sz, output logic wr);
      logic [38:0] e;
      bit          done;
      bit          ld;
      int          stall_n;
      ld = op_is_load(op);
      sb_q.push_back({ld, ld & wen, wa, exp_wdata});
      aluop = op; mem_addr = addr; reg1 = r1; waddr_in = wa; we_in = wen;
      wdata_in = 32'h5A5A5A5A; wb_stall = 1'b0;
      stall_n = 0; done = 0; strb = '0; dwd = '0; sz = '0; wr = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         dbus.daddr_ok = (cyc == aok_at);
         dbus.ddata_ok = (cyc == aok_at + dok_after);
         dbus.drdata   = (cyc == aok_at + dok_after) ? rdata : 32'h0;
         #1;
         if (cyc == 0) begin
            chk({name, " dreq_same_cycle"}, {31'd0, dbus.dreq}, 32'd1);
            strb = dbus.dwstrb; dwd = dbus.dwdata; sz = dbus.dsize; wr = dbus.dwr;
         end
         if (stallreq) begin
            stall_n++;
            step();
         end else if (cyc > 0) begin
            done = 1;
            dbus.daddr_ok = 1'b0; dbus.ddata_ok = 1'b0;
            chk({name, " stall_cycles"}, stall_n, aok_at + dok_after + 1);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            for (int k = 0; k <= wbs; k++) begin
               wb_stall = (k < wbs);
               #1;
               if (e[38]) chk($sformatf("%s wdata_done%0d", name, k), wdata_out, e[31:0]);
               chk($sformatf("%s we_done%0d", name, k), {31'd0, we_out}, {31'd0, e[37]});
               chk($sformatf("%s waddr_done%0d", name, k), {27'd0, waddr_out}, {27'd0, e[36:32]});
               chk($sformatf("%s dreq_done%0d", name, k), {31'd0, dbus.dreq}, 32'd0);
               step();
            end
            wb_stall = 1'b0;
            aluop = EXE_OP_NOP; wdata_in = 32'h0000C0DE;
            #1;
            chk({name, " idle_after"}, wdata_out, 32'h0000C0DE);
         end else begin
            step();
         end
      end
      if (!done) chk({name, " timeout"}, 32'd0, 32'd1);
      dbus.daddr_ok = 1'b0; dbus.ddata_ok = 1'b0;
   endtask

   logic [3:0]  strb;
   logic [31:0] dwd;
   logic [1:0]  sz;
   logic        wr;

   initial begin
      rst = 1'b0; aluop = EXE_OP_LW; mem_addr = 32'h1000; reg1 = 32'h0;
      wdata_in = 32'h1234; waddr_in = 5'd9; we_in = 1'b1; wb_stall = 1'b0;
      dbus.daddr_ok = 1'b0; dbus.ddata_ok = 1'b0; dbus.drdata = 32'h0;
      step(); step();
      chk("reset dreq", {31'd0, dbus.dreq}, 32'd0);
      chk("reset stallreq", {31'd0, stallreq}, 32'd0);
      chk("reset we", {31'd0, we_out}, 32'd0);
      chk("reset wdata", wdata_out, 32'd0);
      chk("reset misalign", {30'd0, misalign}, 32'd0);
      aluop = EXE_OP_NOP;
      step();
      rst = 1'b1;

      aluop = EXE_OP_ADD; wdata_in = 32'h5; waddr_in = 5'd3; we_in = 1'b1;
      #1;
      chk("add wdata", wdata_out, 32'h5);
      chk("add waddr", {27'd0, waddr_out}, 32'd3);
      chk("add we", {31'd0, we_out}, 32'd1);
      chk("add stallreq", {31'd0, stallreq}, 32'd0);
      step();

      access("lw", EXE_OP_LW, 32'h1000, 32'h0, 5'd4, 1'b1, 1, 3, 32'hDEADBEEF, 32'hDEADBEEF, 0,
             strb, dwd, sz, wr);
      chk("lw dwstrb", {28'd0, strb}, 32'd0);
      chk("lw dsize", {30'd0, sz}, 32'd2);
      step();
      access("lb", EXE_OP_LB, 32'h1003, 32'h0, 5'd5, 1'b1, 0, 1, 32'h80123456, 32'hFFFFFF80, 0,
             strb, dwd, sz, wr);
      chk("lb dwr", {31'd0, wr}, 32'd0);
      step();
      access("lbu", EXE_OP_LBU, 32'h1003, 32'h0, 5'd6, 1'b1, 2, 2, 32'h80123456, 32'h00000080, 0,
             strb, dwd, sz, wr);
      step();
      access("lhu", EXE_OP_LHU, 32'h1002, 32'h0, 5'd7, 1'b1, 0, 2, 32'h80123456, 32'h00008012, 0,
             strb, dwd, sz, wr);
      step();
      access("lh", EXE_OP_LH, 32'h1000, 32'h0, 5'd8, 1'b1, 0, 1, 32'h12348001, 32'hFFFF8001, 0,
             strb, dwd, sz, wr);
      step();
      access("sh", EXE_OP_SH, 32'h1002, 32'h0000ABCD, 5'd10, 1'b1, 1, 1, 32'h0, 32'h0, 0,
             strb, dwd, sz, wr);
      chk("sh dwstrb", {28'd0, strb}, 32'hC);
      chk("sh dwdata", dwd, 32'hABCDABCD);
      chk("sh dsize", {30'd0, sz}, 32'd1);
      chk("sh dwr", {31'd0, wr}, 32'd1);
      step();
      access("sb", EXE_OP_SB, 32'h1001, 32'h00000077, 5'd11, 1'b1, 0, 1, 32'h0, 32'h0, 0,
             strb, dwd, sz, wr);
      chk("sb dwstrb", {28'd0, strb}, 32'h2);
      chk("sb dwdata", dwd, 32'h77777777);
      step();
      access("sw", EXE_OP_SW, 32'h1004, 32'h13579BDF, 5'd12, 1'b0, 0, 1, 32'h0, 32'h0, 0,
             strb, dwd, sz, wr);
      chk("sw dwstrb", {28'd0, strb}, 32'hF);
      chk("sw dwdata", dwd, 32'h13579BDF);
      step();
      access("lw_wbstall", EXE_OP_LW, 32'h2000, 32'h0, 5'd13, 1'b1, 0, 1, 32'h0BADF00D,
             32'h0BADF00D, 2, strb, dwd, sz, wr);
      step();

      aluop = EXE_OP_LW; mem_addr = 32'h1002; we_in = 1'b1; wdata_in = 32'h99;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mis_lw dreq%0d", i), {31'd0, dbus.dreq}, 32'd0);
         chk($sformatf("mis_lw misalign%0d", i), {30'd0, misalign}, 32'd1);
         chk($sformatf("mis_lw badvaddr%0d", i), badvaddr, 32'h1002);
         chk($sformatf("mis_lw we%0d", i), {31'd0, we_out}, 32'd0);
         chk($sformatf("mis_lw stallreq%0d", i), {31'd0, stallreq}, 32'd0);
         step();
      end
      aluop = EXE_OP_SH; mem_addr = 32'h1001;
      #1;
      chk("mis_sh misalign", {30'd0, misalign}, 32'd2);
      chk("mis_sh dreq", {31'd0, dbus.dreq}, 32'd0);
      step();

      aluop = EXE_OP_LW; mem_addr = 32'h3000; waddr_in = 5'd7; we_in = 1'b1;
      dbus.daddr_ok = 1'b1;
      step();
      dbus.daddr_ok = 1'b0;
      #1;
      chk("rstw wait_stall", {31'd0, stallreq}, 32'd1);
      chk("rstw wait_dreq", {31'd0, dbus.dreq}, 32'd0);
      rst = 1'b0; aluop = EXE_OP_NOP; wdata_in = 32'h0; waddr_in = 5'd0; we_in = 1'b0;
      step();
      chk("rstw dreq", {31'd0, dbus.dreq}, 32'd0);
      chk("rstw stallreq", {31'd0, stallreq}, 32'd0);
      chk("rstw wdata", wdata_out, 32'd0);
      rst = 1'b1; wdata_in = 32'h77; waddr_in = 5'd4; we_in = 1'b1;
      dbus.ddata_ok = 1'b1; dbus.drdata = 32'hCAFEF00D;
      #1;
      chk("rstw idle_stall", {31'd0, stallreq}, 32'd0);
      step();
      dbus.ddata_ok = 1'b0;
      #1;
      chk("rstw stale_ignored", wdata_out, 32'h77);
      chk("rstw stale_stall", {31'd0, stallreq}, 32'd0);
      chk("scoreboard empty", sb_q.size(), 32'd0);
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
